// File: rtl/cpu_regfile_sync_nr1w_if.sv
// Bundles the register file's read and write ports plus the busy and out-of-bounds status.
// Latency: none; this is wiring only.
// Backpressure: none; the core holds off issue while o_busy is high.
interface cpu_regfile_sync_nr1w_if #(
    parameter int p_xlen       = 32,
    parameter int p_read_ports = 2
);
    logic [p_read_ports-1:0]        i_rd_en;
    logic [5*p_read_ports-1:0]      i_rd_addr;
    logic [p_xlen*p_read_ports-1:0] o_rd_data;
    logic                           i_wr_en;
    logic [4:0]                     i_wr_addr;
    logic [p_xlen-1:0]              i_wr_data;
    logic                           o_busy;
    logic                           o_addr_oob;

    // Core (decode/issue) side
    modport master (
        output i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  o_rd_data, o_busy, o_addr_oob
    );

    // Register file side
    modport slave (
        input  i_rd_en, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
        output o_rd_data, o_busy, o_addr_oob
    );
endinterface

// File: rtl/cpu_regfile_sync_nr1w.sv
// N-read/1-write register file (16 or 32 entries) that clears itself after reset; x0 reads as zero.
// Latency: 1 cycle on reads; a write lands at the edge where it is presented. CPU_REGFILE_BYPASS_EN selects same-edge write-first forwarding.
// Backpressure: o_busy is high during the post-reset clear; external writes are dropped and reads return 0 until it falls.
module cpu_regfile_sync_nr1w #(
    parameter int p_xlen           = 32,
    parameter int p_half_regfile   = 0,
    parameter int p_read_ports     = 2,
    parameter int p_clear_on_reset = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    cpu_regfile_sync_nr1w_if.slave rf
);
    localparam int D  = (p_half_regfile != 0) ? 16 : 32;
    localparam int AW = (p_half_regfile != 0) ? 4 : 5;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_ENTRY = (p_clear_on_reset != 0) ? ST_CLEAR : ST_READY;
    localparam logic [4:0] LAST_IDX = 5'(D - 1);

    logic [0:0]        state;
    logic [4:0]        clr_idx;
    logic              clearing;
    logic              wr_ok;
    logic              oob;
    logic [p_xlen-1:0] regs [D];
    logic [p_read_ports-1:0][p_xlen-1:0] rd_q;

    // Upper half of the address space is missing on a 16-entry file; such addresses are never aliased.
    function automatic logic addr_is_oob(input logic [4:0] a);
        return (p_half_regfile != 0) && a[4];
    endfunction

    assign clearing = (state == ST_CLEAR);
    assign wr_ok    = !clearing && rf.i_wr_en && (rf.i_wr_addr != 5'd0) && !addr_is_oob(rf.i_wr_addr);

    // Clear sequencer: walk regs[1..D-1] once after reset, then stay in READY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_ENTRY;
            clr_idx <= 5'd1;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 5'd1;
            if (clr_idx == LAST_IDX) begin
                state <= ST_READY;
            end
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it. Entry 0 is never written or read.
    always_ff @(posedge i_clk) begin
        if (clearing) begin
            regs[clr_idx[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            regs[rf.i_wr_addr[AW-1:0]] <= rf.i_wr_data;
        end
    end

    for (genvar k = 0; k < p_read_ports; k++) begin : g_rd
        logic [4:0]        addr;
        logic [p_xlen-1:0] q;

        assign addr = rf.i_rd_addr[5*k +: 5];

`ifdef CPU_REGFILE_BYPASS_EN
        logic hit_wr;
        assign hit_wr = wr_ok && (rf.i_wr_addr == addr);
`endif

        // Registered read port: hold when disabled, zero for x0/out-of-bounds/clearing.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else if (rf.i_rd_en[k]) begin
                if (clearing || (addr == 5'd0) || addr_is_oob(addr)) begin
                    q <= '0;
`ifdef CPU_REGFILE_BYPASS_EN
                end else if (hit_wr) begin
                    q <= rf.i_wr_data;
`endif
                end else begin
                    q <= regs[addr[AW-1:0]];
                end
            end
        end

        assign rd_q[k] = q;
    end

    // Out-of-bounds flag looks only at ports that are actually being used this cycle.
    always_comb begin
        oob = rf.i_wr_en && addr_is_oob(rf.i_wr_addr);
        for (int k = 0; k < p_read_ports; k++) begin
            if (rf.i_rd_en[k] && addr_is_oob(rf.i_rd_addr[5*k +: 5])) begin
                oob = 1'b1;
            end
        end
    end

    assign rf.o_rd_data  = rd_q;
    assign rf.o_busy     = clearing;
    assign rf.o_addr_oob = oob;
endmodule

// File: tb/tb_cpu_regfile_sync_nr1w.sv
module tb_cpu_regfile_sync_nr1w;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 i_clk = ~i_clk;

    cpu_regfile_sync_nr1w_if #(.p_xlen(32), .p_read_ports(2)) bus_a ();
    cpu_regfile_sync_nr1w_if #(.p_xlen(32), .p_read_ports(2)) bus_b ();

    // Full 32-entry file
    cpu_regfile_sync_nr1w #(
        .p_xlen(32), .p_half_regfile(0), .p_read_ports(2), .p_clear_on_reset(1)
    ) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .rf(bus_a)
    );

    // 16-entry (RV32E) file
    cpu_regfile_sync_nr1w #(
        .p_xlen(32), .p_half_regfile(1), .p_read_ports(2), .p_clear_on_reset(1)
    ) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .rf(bus_b)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.i_rd_en = 2'b00; bus_a.i_rd_addr = '0;
        bus_a.i_wr_en = 1'b0;  bus_a.i_wr_addr = '0; bus_a.i_wr_data = '0;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [31:0] d);
        bus_a.i_wr_en = 1'b1; bus_a.i_wr_addr = a; bus_a.i_wr_data = d;
        tick();
        bus_a.i_wr_en = 1'b0;
    endtask

    // Counts edges until both files drop busy; bounded so a stuck FSM still reaches the summary.
    task automatic count_busy(output int cnt_a, output int cnt_b);
        bit done_a = 0;
        bit done_b = 0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!done_a) begin
                cnt_a++;
                if (!bus_a.o_busy) done_a = 1;
            end
            if (!done_b) begin
                cnt_b++;
                if (!bus_b.o_busy) done_b = 1;
            end
        end
    endtask

    initial begin
        int ca, cb;
        logic [31:0] bypass_exp;

        idle_a();
        bus_b.i_rd_en = 2'b00; bus_b.i_rd_addr = '0;
        bus_b.i_wr_en = 1'b0;  bus_b.i_wr_addr = '0; bus_b.i_wr_data = '0;

        // Reset state
        #3;
        check("rst_busy_a", 64'(bus_a.o_busy), 64'd1);
        check("rst_busy_b", 64'(bus_b.o_busy), 64'd1);
        check("rst_rd_a", 64'(bus_a.o_rd_data), 64'd0);
        check("rst_oob_a", 64'(bus_a.o_addr_oob), 64'd0);
        tick();
        i_rst_n = 1'b1;

        // Busy duration: 31 edges for 32 entries, 15 for 16
        count_busy(ca, cb);
        check("busy_cycles_a", 64'(ca), 64'd31);
        check("busy_cycles_b", 64'(cb), 64'd15);

        // Every register reads zero after the clear, on both ports
        bus_a.i_rd_en = 2'b11;
        for (int a = 0; a < 32; a++) begin
            bus_a.i_rd_addr = {5'(31 - a), 5'(a)};
            tick();
            check($sformatf("clr_p0_x%0d", a), 64'(bus_a.o_rd_data[31:0]), 64'd0);
            check($sformatf("clr_p1_x%0d", 31 - a), 64'(bus_a.o_rd_data[63:32]), 64'd0);
        end
        idle_a();

        // Write x5, read it back next cycle alongside x0
        write_a(5'd5, 32'hDEADBEEF);
        bus_a.i_rd_en = 2'b11; bus_a.i_rd_addr = {5'd0, 5'd5};
        tick();
        check("x5_p0", 64'(bus_a.o_rd_data[31:0]), 64'hDEADBEEF);
        check("x0_p1", 64'(bus_a.o_rd_data[63:32]), 64'd0);
        idle_a();

        // Writes to x0 are dropped
        write_a(5'd0, 32'h1234);
        bus_a.i_rd_en = 2'b11; bus_a.i_rd_addr = {5'd0, 5'd0};
        tick();
        check("x0_after_wr_p0", 64'(bus_a.o_rd_data[31:0]), 64'd0);
        check("x0_after_wr_p1", 64'(bus_a.o_rd_data[63:32]), 64'd0);
        idle_a();

        // Same-edge read/write of x7
        write_a(5'd7, 32'h11);
        bus_a.i_wr_en = 1'b1; bus_a.i_wr_addr = 5'd7; bus_a.i_wr_data = 32'hA5A5A5A5;
        bus_a.i_rd_en = 2'b01; bus_a.i_rd_addr = {5'd0, 5'd7};
        tick();
`ifdef CPU_REGFILE_BYPASS_EN
        bypass_exp = 32'hA5A5A5A5;
`else
        bypass_exp = 32'h11;
`endif
        check("x7_same_edge", 64'(bus_a.o_rd_data[31:0]), 64'(bypass_exp));
        bus_a.i_wr_en = 1'b0;
        tick();
        check("x7_next", 64'(bus_a.o_rd_data[31:0]), 64'hA5A5A5A5);
        idle_a();

        // Disabled port holds while its register changes
        write_a(5'd9, 32'h1);
        bus_a.i_rd_en = 2'b10; bus_a.i_rd_addr = {5'd9, 5'd0};
        tick();
        check("x9_p1_first", 64'(bus_a.o_rd_data[63:32]), 64'h1);
        bus_a.i_rd_en = 2'b00;
        write_a(5'd9, 32'h2);
        check("x9_p1_hold0", 64'(bus_a.o_rd_data[63:32]), 64'h1);
        tick();
        check("x9_p1_hold1", 64'(bus_a.o_rd_data[63:32]), 64'h1);
        bus_a.i_rd_en = 2'b10;
        tick();
        check("x9_p1_reen", 64'(bus_a.o_rd_data[63:32]), 64'h2);
        idle_a();

        // Out-of-bounds write on the 16-entry file is flagged and suppressed
        bus_b.i_wr_en = 1'b1; bus_b.i_wr_addr = 5'd17; bus_b.i_wr_data = 32'hFFFF;
        bus_a.i_rd_en = 2'b01; bus_a.i_rd_addr = {5'd0, 5'd17};
        #1;
        check("oob_b_wr", 64'(bus_b.o_addr_oob), 64'd1);
        check("oob_a_full", 64'(bus_a.o_addr_oob), 64'd0);
        tick();
        bus_b.i_wr_en = 1'b0;
        idle_a();
        bus_b.i_rd_en = 2'b11; bus_b.i_rd_addr = {5'd17, 5'd1};
        #1;
        check("oob_b_rd", 64'(bus_b.o_addr_oob), 64'd1);
        tick();
        check("b_x1_no_alias", 64'(bus_b.o_rd_data[31:0]), 64'd0);
        check("b_a17_zero", 64'(bus_b.o_rd_data[63:32]), 64'd0);
        bus_b.i_rd_en = 2'b01; bus_b.i_rd_addr = {5'd0, 5'd1};
        #1;
        check("oob_b_inb", 64'(bus_b.o_addr_oob), 64'd0);
        bus_b.i_rd_en = 2'b00;

        // Reset mid-clear restarts the sequence from register 1
        write_a(5'd3, 32'hCAFE);
        write_a(5'd20, 32'hBEEF);
        bus_a.i_rd_en = 2'b11; bus_a.i_rd_addr = {5'd20, 5'd3};
        tick();
        check("x3_before", 64'(bus_a.o_rd_data[31:0]), 64'hCAFE);
        check("x20_before", 64'(bus_a.o_rd_data[63:32]), 64'hBEEF);
        idle_a();
        i_rst_n = 1'b0;
        #2;
        check("rst2_busy", 64'(bus_a.o_busy), 64'd1);
        check("rst2_rd", 64'(bus_a.o_rd_data), 64'd0);
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("mid_clear_busy", 64'(bus_a.o_busy), 64'd1);
        i_rst_n = 1'b0;
        #2;
        check("rst3_busy", 64'(bus_a.o_busy), 64'd1);
        tick();
        i_rst_n = 1'b1;
        count_busy(ca, cb);
        check("busy_restart_a", 64'(ca), 64'd31);
        check("busy_restart_b", 64'(cb), 64'd15);
        bus_a.i_rd_en = 2'b11; bus_a.i_rd_addr = {5'd20, 5'd3};
        tick();
        check("x3_after", 64'(bus_a.o_rd_data[31:0]), 64'd0);
        check("x20_after", 64'(bus_a.o_rd_data[63:32]), 64'd0);
        idle_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
